frame_rd_dma: RTL

- Parametrised frame-read engine for the DDR3-to-HDMI display path.
- Issues AXI4 read bursts that stream one active frame from a DDR3 frame buffer into the pixel frame FIFO. It replaces the fixed single-buffer, almost_full-throttled read with:
  - N-buffer selection (triple buffering against a frame writer);
  - generic resolution and pixel depth;
  - short final burst;
  - FIFO-level credit throttling;
  - bounded outstanding bursts.
- Sits in the AXI clock domain, between the DDR3 controller's AXI slave and the write side of frame_fifo.

---
 rtl/frame_dma_pkg.sv | 28 ++
 rtl/frame_dma_credit.sv | 46 ++++
 rtl/frame_rd_dma.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/frame_dma_pkg.sv
// Shared types, AXI constants and elaboration helpers for the frame read DMA.
package frame_dma_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        ISSUE    = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int frame_beats(input int h_act, input int v_act,
                                       input int bpp, input int data_w);
        return (h_act * v_act * bpp) / data_w;
    endfunction

endpackage

// File: rtl/frame_dma_credit.sv
// Tracks in-flight AR bursts and R beats and decides whether one more burst fits.
module frame_dma_credit #(
    parameter int LVL_W      = 9,
    parameter int FIFO_DEPTH = 512,
    parameter int MAX_OUTST  = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             ar_hs,
    input  logic [8:0]       len,
    input  logic             r_beat,
    input  logic             r_last,
    input  logic [LVL_W-1:0] fifo_level,
    output logic             permit,
    output logic             idle
);

    localparam int SUM_W = LVL_W + 2;

    logic [SUM_W-1:0] outst_beats_reg, outst_beats_next;
    logic [7:0]       outst_bursts_reg, outst_bursts_next;
    logic [SUM_W-1:0] demand;

    // Issue and completion in the same cycle net out in one update.
    always_comb begin
        outst_beats_next  = outst_beats_reg
                          + (ar_hs  ? SUM_W'(len) : '0)
                          - (r_beat ? SUM_W'(1)   : '0);
        outst_bursts_next = outst_bursts_reg + {7'd0, ar_hs} - {7'd0, r_last};
        demand            = SUM_W'(fifo_level) + outst_beats_reg + SUM_W'(len);
        permit            = (outst_bursts_reg < 8'(MAX_OUTST))
                         && (demand <= SUM_W'(FIFO_DEPTH));
        idle              = (outst_bursts_reg == 8'd0);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            outst_beats_reg  <= '0;
            outst_bursts_reg <= '0;
        end else begin
            outst_beats_reg  <= outst_beats_next;
            outst_bursts_reg <= outst_bursts_next;
        end
    end

endmodule

// File: rtl/frame_rd_dma.sv
// Frame read engine: streams one buffered frame from DDR into the pixel FIFO
// with AXI4 INCR bursts, FIFO credit throttling and bounded outstanding reads.
module frame_rd_dma
    import frame_dma_pkg::*;
#(
    parameter int          ADDR_W     = 28,
    parameter int          DATA_W     = 128,
    parameter int          H_ACT      = 1280,
    parameter int          V_ACT      = 720,
    parameter int          BPP        = 16,
    parameter int          BURST_LEN  = 16,
    parameter int          NUM_BUF    = 3,
    parameter logic [31:0] BUF_STRIDE = 32'h0020_0000,
    parameter int          MAX_OUTST  = 4,
    parameter int          FIFO_DEPTH = 512,
    parameter int          LVL_W      = 9
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              frame_start,
    input  logic              wr_done,
    input  logic [1:0]        wr_idx,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic [LVL_W-1:0]  fifo_wr_level,
    output logic [1:0]        rd_idx,
    output logic              busy,
    output logic              frame_done,
    output logic              late_err,
    output logic              resp_err
);

    localparam int FRAME_BEATS = frame_beats(H_ACT, V_ACT, BPP, DATA_W);
    localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;

    if (FRAME_BEATS * DATA_W != H_ACT * V_ACT * BPP) begin : g_bad_frame
        $error("frame_rd_dma: frame size is not a whole number of data beats");
    end
    if (NUM_BUF < 1 || NUM_BUF > 4 || BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_cfg
        $error("frame_rd_dma: NUM_BUF or BURST_LEN out of range");
    end

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] next_addr_reg, araddr_reg;
    logic [7:0]        arlen_reg;
    logic              arvalid_reg;
    logic [31:0]       beats_left_reg, beats_after;
    logic [1:0]        latest_done_reg, rd_idx_reg;
    logic              busy_reg, frame_done_reg, late_err_reg, resp_err_reg;
    logic [8:0]        len;
    logic              ar_hs, r_beat, permit, credit_idle;
    logic              issue_now, sof_take, drain_exit;

    assign rready       = !sys_rst;
    assign r_beat       = rvalid & rready;
    assign fifo_wr_en   = r_beat;
    assign fifo_wr_data = rdata;
    assign ar_hs        = arvalid_reg & arready;

    assign araddr     = araddr_reg;
    assign arlen      = arlen_reg;
    assign arvalid    = arvalid_reg;
    assign arsize     = 3'(clog2(DATA_W / 8));
    assign arburst    = BURST_INCR;
    assign rd_idx     = rd_idx_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign late_err   = late_err_reg;
    assign resp_err   = resp_err_reg;

    // beats_left only moves on a handshake, so len stays consistent with a pending arlen.
    assign len         = (beats_left_reg >= 32'(BURST_LEN)) ? 9'(BURST_LEN) : beats_left_reg[8:0];
    assign beats_after = ar_hs ? (beats_left_reg - 32'(len)) : beats_left_reg;

    frame_dma_credit #(
        .LVL_W      (LVL_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_OUTST  (MAX_OUTST)
    ) u_credit (
        .clk        (sys_clk),
        .srst       (sys_rst),
        .ar_hs      (ar_hs),
        .len        (len),
        .r_beat     (r_beat),
        .r_last     (r_beat & rlast),
        .fifo_level (fifo_wr_level),
        .permit     (permit),
        .idle       (credit_idle)
    );

    always_comb begin
        state_next = state_reg;
        sof_take   = 1'b0;
        drain_exit = 1'b0;
        issue_now  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) state_next = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (frame_start) begin
                    state_next = ISSUE;
                    sof_take   = 1'b1;
                end
            end
            ISSUE: begin
                issue_now = !arvalid_reg && enable && (beats_left_reg != 32'd0) && permit;
                // A pending AR must complete before leaving, even if enable dropped.
                if ((!arvalid_reg || ar_hs) && (beats_after == 32'd0 || !enable)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (credit_idle) begin
                    drain_exit = 1'b1;
                    state_next = enable ? WAIT_SOF : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            next_addr_reg   <= '0;
            araddr_reg      <= '0;
            arlen_reg       <= '0;
            arvalid_reg     <= 1'b0;
            beats_left_reg  <= '0;
            latest_done_reg <= '0;
            rd_idx_reg      <= '0;
            busy_reg        <= 1'b0;
            frame_done_reg  <= 1'b0;
            late_err_reg    <= 1'b0;
            resp_err_reg    <= 1'b0;
        end else begin
            if (wr_done && (32'(wr_idx) < NUM_BUF)) latest_done_reg <= wr_idx;
            if (frame_start && busy_reg)            late_err_reg    <= 1'b1;
            if (r_beat && rresp != RESP_OKAY)       resp_err_reg    <= 1'b1;

            if (sof_take) begin
                rd_idx_reg     <= latest_done_reg;
                next_addr_reg  <= base_addr + ADDR_W'(latest_done_reg) * ADDR_W'(BUF_STRIDE);
                beats_left_reg <= 32'(FRAME_BEATS);
                busy_reg       <= 1'b1;
            end

            if (issue_now) begin
                arvalid_reg <= 1'b1;
                araddr_reg  <= next_addr_reg;
                arlen_reg   <= 8'(len - 9'd1);
            end

            if (ar_hs) begin
                arvalid_reg    <= 1'b0;
                next_addr_reg  <= next_addr_reg + ADDR_W'(BURST_BYTES);
                beats_left_reg <= beats_after;
            end

            frame_done_reg <= drain_exit;
            if (drain_exit) busy_reg <= 1'b0;
        end
    end

endmodule
